// File: rtl/operand_issue_stage_pkg.sv
// Shared definitions for the operand issue stage and the execution unit it feeds.
// Holds datapath width defaults, RV32 opcode constants, instruction field
// positions and small decode helpers.
package operand_issue_stage_pkg;

   localparam int WIDTH_DEF   = 32;
   localparam int FWIDTH_DEF  = 3;
   localparam int AFWIDTH_DEF = 7;
   localparam int RADDR_DEF   = 5;

   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM = 7'b0010011;

   localparam int OPC_LSB  = 0;
   localparam int RD_LSB   = 7;
   localparam int FUNC_LSB = 12;
   localparam int RS1_LSB  = 15;
   localparam int RS2_LSB  = 20;
   localparam int IMM_LSB  = 20;
   localparam int AUX_LSB  = 25;

   localparam logic [2:0] FUNC_SLL = 3'b001;
   localparam logic [2:0] FUNC_SRX = 3'b101;

   typedef enum logic [1:0] {
      CLS_OP      = 2'd0,
      CLS_OPIMM   = 2'd1,
      CLS_ILLEGAL = 2'd2
   } instr_class_e;

   function automatic instr_class_e classify(input logic [6:0] opc);
      instr_class_e cls;
      cls = CLS_ILLEGAL;
      if (opc == OPC_OP) begin
         cls = CLS_OP;
      end else if (opc == OPC_OPIMM) begin
         cls = CLS_OPIMM;
      end
      return cls;
   endfunction

   // Immediate shifts carry their shift type (SRLI vs SRAI) in instr[31:25].
   function automatic logic is_shift(input logic [2:0] func);
      return (func == FUNC_SLL) || (func == FUNC_SRX);
   endfunction

endpackage

// File: rtl/operand_issue_stage_scoreboard.sv
// issue_scoreboard: one busy bit per architectural register.
// Ports:
//   clk, rst_n          clock, async active-low reset (clears every busy bit)
//   set_en, set_addr    mark a register busy (issuing op's destination)
//   clr_en, clr_addr    clear a register (writeback completed)
//   query_a_addr/busy   combinational busy lookup, operand A
//   query_b_addr/busy   combinational busy lookup, operand B
// A set and a clear of the same register in one cycle leaves it busy: the
// issuing op is younger than the one writing back. Register 0 never goes busy.
import operand_issue_stage_pkg::*;

module issue_scoreboard #(
   parameter int RADDR = RADDR_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             set_en,
   input  logic [RADDR-1:0] set_addr,
   input  logic             clr_en,
   input  logic [RADDR-1:0] clr_addr,
   input  logic [RADDR-1:0] query_a_addr,
   output logic             query_a_busy,
   input  logic [RADDR-1:0] query_b_addr,
   output logic             query_b_busy
);

   localparam int NREG = 2 ** RADDR;

   logic [NREG-1:0] busy;
   logic [NREG-1:0] busy_nxt;

   always_comb begin
      busy_nxt = busy;
      if (clr_en) begin
         busy_nxt[clr_addr] = 1'b0;
      end
      if (set_en) begin
         busy_nxt[set_addr] = 1'b1;
      end
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= '0;
      end else begin
         busy <= busy_nxt;
      end
   end

   assign query_a_busy = busy[query_a_addr];
   assign query_b_busy = busy[query_b_addr];

endmodule

// File: rtl/operand_issue_stage.sv
// operand_issue_stage: issue stage in front of the execution unit.
// Accepts one RV32 OP / OP-IMM instruction per cycle, reads rs1/rs2 from the
// register file, forms opA/opB/func/auxFunc and holds them in an output
// register with a valid/ready handshake. RAW hazards on busy registers stall
// until the matching writeback, whose data is bypassed in the same cycle.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   in_valid/in_ready/in_instr     instruction input handshake
//   rs1_addr/rs2_addr              register file read addresses (combinational)
//   rs1_data/rs2_data              register file read data
//   wb_valid/wb_rd/wb_data         writeback completion + bypass value
//   ex_valid/ex_ready              output handshake
//   ex_opA/ex_opB/ex_func/ex_auxFunc/ex_rd/ex_illegal  issued op payload
import operand_issue_stage_pkg::*;

module operand_issue_stage #(
   parameter int WIDTH   = WIDTH_DEF,
   parameter int FWIDTH  = FWIDTH_DEF,
   parameter int AFWIDTH = AFWIDTH_DEF,
   parameter int RADDR   = RADDR_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_instr,
   output logic [RADDR-1:0]   rs1_addr,
   output logic [RADDR-1:0]   rs2_addr,
   input  logic [WIDTH-1:0]   rs1_data,
   input  logic [WIDTH-1:0]   rs2_data,
   input  logic               wb_valid,
   input  logic [RADDR-1:0]   wb_rd,
   input  logic [WIDTH-1:0]   wb_data,
   output logic               ex_valid,
   input  logic               ex_ready,
   output logic [WIDTH-1:0]   ex_opA,
   output logic [WIDTH-1:0]   ex_opB,
   output logic [FWIDTH-1:0]  ex_func,
   output logic [AFWIDTH-1:0] ex_auxFunc,
   output logic [RADDR-1:0]   ex_rd,
   output logic               ex_illegal
);

   logic [6:0]         opcode;
   logic [RADDR-1:0]   rd;
   logic [RADDR-1:0]   rs1;
   logic [RADDR-1:0]   rs2;
   logic [FWIDTH-1:0]  func;
   logic [AFWIDTH-1:0] aux;
   logic [11:0]        imm;
   logic [WIDTH-1:0]   imm_sext;

   instr_class_e cls;
   logic         is_op;
   logic         is_opimm;
   logic         legal;

   logic wb_hit1;
   logic wb_hit2;
   logic busy1;
   logic busy2;
   logic hazard;
   logic accept;

   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b_reg;

   logic [WIDTH-1:0]   dec_opA;
   logic [WIDTH-1:0]   dec_opB;
   logic [FWIDTH-1:0]  dec_func;
   logic [AFWIDTH-1:0] dec_aux;
   logic [RADDR-1:0]   dec_rd;
   logic               dec_illegal;

   assign opcode   = in_instr[OPC_LSB  +: 7];
   assign rd       = in_instr[RD_LSB   +: RADDR];
   assign func     = in_instr[FUNC_LSB +: FWIDTH];
   assign rs1      = in_instr[RS1_LSB  +: RADDR];
   assign rs2      = in_instr[RS2_LSB  +: RADDR];
   assign imm      = in_instr[IMM_LSB  +: 12];
   assign aux      = in_instr[AUX_LSB  +: AFWIDTH];
   assign imm_sext = {{(WIDTH-12){imm[11]}}, imm};

   assign rs1_addr = rs1;
   assign rs2_addr = rs2;

   assign cls      = classify(opcode);
   assign is_op    = (cls == CLS_OP);
   assign is_opimm = (cls == CLS_OPIMM);
   assign legal    = is_op | is_opimm;

   assign wb_hit1 = wb_valid & (wb_rd == rs1) & (wb_rd != '0);
   assign wb_hit2 = wb_valid & (wb_rd == rs2) & (wb_rd != '0);

   // OP-IMM reuses the rs2 field as immediate bits, so only OP checks rs2.
   // Illegal instructions never read operands and so never stall.
   assign hazard = legal &
                   (((rs1 != '0) & busy1 & ~wb_hit1) |
                    (is_op & (rs2 != '0) & busy2 & ~wb_hit2));

   assign in_ready = (~ex_valid | ex_ready) & ~hazard;
   assign accept   = in_valid & in_ready;

   assign op_a     = (rs1 == '0) ? '0 : (wb_hit1 ? wb_data : rs1_data);
   assign op_b_reg = (rs2 == '0) ? '0 : (wb_hit2 ? wb_data : rs2_data);

   always_comb begin
      dec_opA     = '0;
      dec_opB     = '0;
      dec_func    = '0;
      dec_aux     = '0;
      dec_rd      = '0;
      dec_illegal = 1'b0;
      if (legal) begin
         dec_opA  = op_a;
         dec_func = func;
         dec_rd   = rd;
         if (is_op) begin
            dec_opB = op_b_reg;
            dec_aux = aux;
         end else begin
            dec_opB = imm_sext;
            if (is_shift(func)) begin
               dec_aux = aux;
            end
         end
      end else begin
         dec_illegal = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid   <= 1'b0;
         ex_opA     <= '0;
         ex_opB     <= '0;
         ex_func    <= '0;
         ex_auxFunc <= '0;
         ex_rd      <= '0;
         ex_illegal <= 1'b0;
      end else if (accept) begin
         ex_valid   <= 1'b1;
         ex_opA     <= dec_opA;
         ex_opB     <= dec_opB;
         ex_func    <= dec_func;
         ex_auxFunc <= dec_aux;
         ex_rd      <= dec_rd;
         ex_illegal <= dec_illegal;
      end else if (ex_ready) begin
         ex_valid <= 1'b0;
      end
   end

   issue_scoreboard #(
      .RADDR (RADDR)
   ) u_scoreboard (
      .clk          (clk),
      .rst_n        (rst_n),
      .set_en       (accept & legal & (rd != '0)),
      .set_addr     (rd),
      .clr_en       (wb_valid),
      .clr_addr     (wb_rd),
      .query_a_addr (rs1),
      .query_a_busy (busy1),
      .query_b_addr (rs2),
      .query_b_busy (busy2)
   );

endmodule

// File: tb/tb_operand_issue_stage.sv
module tb_operand_issue_stage;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  f;
      logic [6:0]  x;
      logic [4:0]  rd;
      logic        ill;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_instr = '0;
   logic [4:0]  rs1_addr;
   logic [4:0]  rs2_addr;
   logic [31:0] rs1_data = '0;
   logic [31:0] rs2_data = '0;
   logic        wb_valid = 1'b0;
   logic [4:0]  wb_rd = '0;
   logic [31:0] wb_data = '0;
   logic        ex_valid;
   logic        ex_ready = 1'b1;
   logic [31:0] ex_opA;
   logic [31:0] ex_opB;
   logic [2:0]  ex_func;
   logic [6:0]  ex_auxFunc;
   logic [4:0]  ex_rd;
   logic        ex_illegal;

   int   total = 0;
   int   bad = 0;
   exp_t q[$];
   exp_t mon_e;

   localparam logic [31:0] I_ADD3  = 32'h002081B3; // add  x3,x1,x2
   localparam logic [31:0] I_ADD7  = 32'h002083B3; // add  x7,x1,x2
   localparam logic [31:0] I_SRAI  = 32'h4030D213; // srai x4,x1,3
   localparam logic [31:0] I_ADDI5 = 32'hFFF00293; // addi x5,x0,-1
   localparam logic [31:0] I_ADDI8 = 32'h02A00413; // addi x8,x0,42
   localparam logic [31:0] I_SUB6  = 32'h40118333; // sub  x6,x3,x1
   localparam logic [31:0] I_JAL1  = 32'h000000EF; // jal  x1,0
   localparam logic [31:0] I_BAD3  = 32'h00018000; // opcode 0, rs1 field = x3

   always #5 clk = ~clk;

   operand_issue_stage dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_instr   (in_instr),
      .rs1_addr   (rs1_addr),
      .rs2_addr   (rs2_addr),
      .rs1_data   (rs1_data),
      .rs2_data   (rs2_data),
      .wb_valid   (wb_valid),
      .wb_rd      (wb_rd),
      .wb_data    (wb_data),
      .ex_valid   (ex_valid),
      .ex_ready   (ex_ready),
      .ex_opA     (ex_opA),
      .ex_opB     (ex_opB),
      .ex_func    (ex_func),
      .ex_auxFunc (ex_auxFunc),
      .ex_rd      (ex_rd),
      .ex_illegal (ex_illegal)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f,
                               input logic [6:0] x, input logic [4:0] rd, input logic ill);
      exp_t e;
      e.a = a; e.b = b; e.f = f; e.x = x; e.rd = rd; e.ill = ill;
      return e;
   endfunction

   // Reference decode for a hazard-free, bypass-free legal instruction.
   function automatic exp_t model(input logic [31:0] ins, input logic [31:0] d1, input logic [31:0] d2);
      exp_t e;
      e.ill = 1'b0;
      e.rd  = ins[11:7];
      e.f   = ins[14:12];
      e.a   = (ins[19:15] == 5'd0) ? 32'd0 : d1;
      if (ins[6:0] == 7'b0110011) begin
         e.b = (ins[24:20] == 5'd0) ? 32'd0 : d2;
         e.x = ins[31:25];
      end else begin
         e.b = {{20{ins[31]}}, ins[31:20]};
         e.x = (e.f == 3'b001 || e.f == 3'b101) ? ins[31:25] : 7'd0;
      end
      return e;
   endfunction

   // Every consumed op is compared against the oldest expected entry.
   always @(negedge clk) begin
      if (rst_n && ex_valid && ex_ready) begin
         if (q.size() == 0) begin
            chk("unexpected_op", 32'd1, 32'd0);
         end else begin
            mon_e = q.pop_front();
            chk("opA",     ex_opA, mon_e.a);
            chk("opB",     ex_opB, mon_e.b);
            chk("func",    32'(ex_func), 32'(mon_e.f));
            chk("auxFunc", 32'(ex_auxFunc), 32'(mon_e.x));
            chk("rd",      32'(ex_rd), 32'(mon_e.rd));
            chk("illegal", 32'(ex_illegal), 32'(mon_e.ill));
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] ins, input logic [31:0] d1, input logic [31:0] d2);
      in_valid = 1'b1;
      in_instr = ins;
      rs1_data = d1;
      rs2_data = d2;
   endtask

   task automatic accept_now(input string tag, input exp_t e);
      logic r;
      @(negedge clk);
      r = in_ready;
      chk({tag, "_ready"}, 32'(r), 32'd1);
      @(posedge clk);
      if (r && in_valid) q.push_back(e);
      #1;
   endtask

   task automatic stall_chk(input string tag);
      @(negedge clk);
      chk(tag, 32'(in_ready), 32'd0);
      cyc();
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      rst_n = 1'b0;
      q.delete();
      cyc();
      rst_n = 1'b1;
   endtask

   initial begin
      logic [31:0] ins;
      rst_n = 1'b0;
      repeat (2) cyc();
      chk("rst_valid",   32'(ex_valid), 32'd0);
      chk("rst_opA",     ex_opA, 32'd0);
      chk("rst_opB",     ex_opB, 32'd0);
      chk("rst_func",    32'(ex_func), 32'd0);
      chk("rst_aux",     32'(ex_auxFunc), 32'd0);
      chk("rst_rd",      32'(ex_rd), 32'd0);
      chk("rst_illegal", 32'(ex_illegal), 32'd0);
      rst_n = 1'b1;
      cyc();

      // basic OP, immediate shift with auxFunc, x0 source and negative immediate
      drive(I_ADD3, 32'd5, 32'd7);
      accept_now("add", mk(32'd5, 32'd7, 3'b000, 7'd0, 5'd3, 1'b0));
      drive(I_SRAI, 32'h8000_0000, 32'h55);
      accept_now("srai", mk(32'h8000_0000, 32'h403, 3'b101, 7'b0100000, 5'd4, 1'b0));
      drive(I_ADDI5, 32'hDEAD, 32'h55);
      accept_now("addi", mk(32'd0, 32'hFFFF_FFFF, 3'b000, 7'd0, 5'd5, 1'b0));

      // RAW stall released by writeback with same-cycle bypass
      do_reset();
      drive(I_ADD3, 32'd5, 32'd7);
      accept_now("add_raw", mk(32'd5, 32'd7, 3'b000, 7'd0, 5'd3, 1'b0));
      drive(I_SUB6, 32'h0BAD, 32'h11);
      stall_chk("raw_stall0");
      stall_chk("raw_stall1");
      wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h1234;
      accept_now("sub_byp", mk(32'h1234, 32'h11, 3'b000, 7'b0100000, 5'd6, 1'b0));
      wb_valid = 1'b0;

      // output held under backpressure, then released without loss or duplication
      drive(I_ADD7, 32'h100, 32'h200);
      accept_now("add7", mk(32'h100, 32'h200, 3'b000, 7'd0, 5'd7, 1'b0));
      ex_ready = 1'b0;
      drive(I_ADDI8, 32'd0, 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         chk("bp_valid",    32'(ex_valid), 32'd1);
         chk("bp_opA",      ex_opA, 32'h100);
         chk("bp_opB",      ex_opB, 32'h200);
         chk("bp_rd",       32'(ex_rd), 32'd7);
         cyc();
      end
      ex_ready = 1'b1;
      accept_now("addi8", mk(32'd0, 32'd42, 3'b000, 7'd0, 5'd8, 1'b0));

      // illegal opcode: zero payload, no busy bit, hazards ignored
      drive(I_JAL1, 32'h77, 32'h88);
      accept_now("jal", mk(32'd0, 32'd0, 3'b000, 7'd0, 5'd0, 1'b1));
      drive(I_ADD3, 32'd9, 32'd10);
      accept_now("after_jal", mk(32'd9, 32'd10, 3'b000, 7'd0, 5'd3, 1'b0));
      drive(I_BAD3, 32'h99, 32'h99);
      accept_now("ill_haz", mk(32'd0, 32'd0, 3'b000, 7'd0, 5'd0, 1'b1));

      // async reset during a stall with an op held in the output register
      ex_ready = 1'b0;
      drive(I_SUB6, 32'h3333, 32'h11);
      stall_chk("rst_stall");
      @(negedge clk);
      chk("pre_rst_valid", 32'(ex_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async_valid", 32'(ex_valid), 32'd0);
      chk("rst_async_ready", 32'(in_ready), 32'd1);
      q.delete();
      cyc();
      rst_n = 1'b1;
      ex_ready = 1'b1;
      accept_now("sub_post_rst", mk(32'h3333, 32'h11, 3'b000, 7'b0100000, 6'd6, 1'b0));

      // independent stream at full throughput
      for (int i = 0; i < 16; i++) begin
         logic [31:0] d1, d2;
         d1 = $urandom;
         d2 = $urandom;
         ins = $urandom;
         ins[19:15] = 5'($urandom_range(0, 5));
         ins[11:7]  = 5'($urandom_range(16, 31));
         if (i % 2 == 0) begin
            ins[6:0]   = 7'b0110011;
            ins[24:20] = 5'($urandom_range(0, 5));
         end else begin
            ins[6:0] = 7'b0010011;
         end
         drive(ins, d1, d2);
         accept_now("stream", model(ins, d1, d2));
      end

      in_valid = 1'b0;
      repeat (4) cyc();
      chk("drain", 32'(q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
